// File: rtl/branch_resolve_unit_pkg.sv
// Shared core constants for branch resolution: jump_type bit positions,
// default widths and opcode classification.
package branch_resolve_unit_pkg;

   localparam int unsigned XLEN_DEFAULT  = 32;
   localparam int unsigned CNT_W_DEFAULT = 32;
   localparam int unsigned JT_W          = 8;

   localparam int unsigned JT_JAL  = 0;
   localparam int unsigned JT_JALR = 1;
   localparam int unsigned JT_BEQ  = 2;
   localparam int unsigned JT_BNE  = 3;
   localparam int unsigned JT_BLT  = 4;
   localparam int unsigned JT_BGE  = 5;
   localparam int unsigned JT_BLTU = 6;
   localparam int unsigned JT_BGEU = 7;

   typedef enum logic [1:0] {
      CLS_NONE    = 2'd0,
      CLS_BRANCH  = 2'd1,
      CLS_ILLEGAL = 2'd2
   } jump_class_e;

   // Zero is a plain instruction, exactly one bit is a control transfer,
   // anything else is an illegal encoding.
   function automatic jump_class_e classify(input logic [JT_W-1:0] jt);
      jump_class_e cls;
      if (jt == '0)
         cls = CLS_NONE;
      else if ((jt & (jt - JT_W'(1))) != '0)
         cls = CLS_ILLEGAL;
      else
         cls = CLS_BRANCH;
      return cls;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Operand comparator: equality, signed and unsigned less-than derived from a
// single XLEN+1 bit subtraction.
module branch_cmp
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            eq,
   output logic            lt,
   output logic            ltu
);

   logic [XLEN:0] diff;

   // The extra top bit of the zero-extended difference is the borrow.
   assign diff = {1'b0, a} - {1'b0, b};
   assign ltu  = diff[XLEN];
   assign eq   = (diff[XLEN-1:0] == '0);
   // Differing signs decide on their own; equal signs reduce to unsigned order.
   assign lt   = (a[XLEN-1] ^ b[XLEN-1]) ? a[XLEN-1] : ltu;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: resolves direction/target of one request per cycle
// into a single output register with valid/ready handshakes and perf counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [JT_W-1:0]   jump_type,
   input  logic [XLEN-1:0]   src1,
   input  logic [XLEN-1:0]   src2,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   imm,
   input  logic              pred_taken,
   input  logic [XLEN-1:0]   pred_target,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_taken,
   output logic [XLEN-1:0]   out_next_pc,
   output logic [XLEN-1:0]   out_link,
   output logic              out_mispredict,
   output logic              out_err,
   output logic [CNT_W-1:0]  branch_cnt,
   output logic [CNT_W-1:0]  mispredict_cnt
);

   logic            cmp_eq;
   logic            cmp_lt;
   logic            cmp_ltu;
   jump_class_e     cls_c;
   logic            taken_c;
   logic            mispred_c;
   logic [XLEN-1:0] link_c;
   logic [XLEN-1:0] target_c;
   logic [XLEN-1:0] next_pc_c;
   logic            out_is_branch;
   logic            accept;
   logic            retire;

   branch_cmp #(
      .XLEN (XLEN)
   ) u_cmp (
      .a   (src1),
      .b   (src2),
      .eq  (cmp_eq),
      .lt  (cmp_lt),
      .ltu (cmp_ltu)
   );

   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready & ~flush;
   assign retire   = out_valid & out_ready & ~flush;

   // Combinational resolution of the request currently presented.
   always_comb begin
      cls_c     = classify(jump_type);
      taken_c   = 1'b0;
      mispred_c = 1'b0;
      link_c    = pc + XLEN'(4);
      target_c  = pc + imm;
      if (jump_type[JT_JALR])
         target_c = (src1 + imm) & ~(XLEN'(1));
      if (cls_c == CLS_BRANCH) begin
         taken_c = jump_type[JT_JAL]  | jump_type[JT_JALR]
                 | (jump_type[JT_BEQ]  &  cmp_eq)
                 | (jump_type[JT_BNE]  & ~cmp_eq)
                 | (jump_type[JT_BLT]  &  cmp_lt)
                 | (jump_type[JT_BGE]  & ~cmp_lt)
                 | (jump_type[JT_BLTU] &  cmp_ltu)
                 | (jump_type[JT_BGEU] & ~cmp_ltu);
         mispred_c = (pred_taken != taken_c) | (taken_c & (pred_target != target_c));
      end else if (cls_c == CLS_NONE) begin
         mispred_c = pred_taken;
      end
      next_pc_c = taken_c ? target_c : link_c;
   end

   // Output register: loads on acceptance, holds under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_taken      <= 1'b0;
         out_next_pc    <= '0;
         out_link       <= '0;
         out_mispredict <= 1'b0;
         out_err        <= 1'b0;
         out_is_branch  <= 1'b0;
      end else if (flush) begin
         out_valid      <= 1'b0;
         out_mispredict <= 1'b0;
         out_err        <= 1'b0;
         out_is_branch  <= 1'b0;
      end else if (in_ready) begin
         out_valid <= accept;
         if (accept) begin
            out_taken      <= taken_c;
            out_next_pc    <= next_pc_c;
            out_link       <= link_c;
            out_mispredict <= mispred_c;
            out_err        <= (cls_c == CLS_ILLEGAL);
            out_is_branch  <= (cls_c == CLS_BRANCH);
         end else begin
            out_mispredict <= 1'b0;
            out_err        <= 1'b0;
            out_is_branch  <= 1'b0;
         end
      end
   end

   // Saturating performance counters, advanced when a legal branch retires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (retire && out_is_branch) begin
         if (branch_cnt != '1)
            branch_cnt <= branch_cnt + CNT_W'(1);
         if (out_mispredict && (mispredict_cnt != '1))
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, a behavioural
// reference model compared every cycle, plus hand-computed spot checks.
module tb_branch_resolve_unit;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       jump_type;
   logic [XLEN-1:0]  src1, src2, pc, imm, pred_target;
   logic             pred_taken;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic             out_taken;
   logic [XLEN-1:0]  out_next_pc;
   logic [XLEN-1:0]  out_link;
   logic             out_mispredict;
   logic             out_err;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .jump_type      (jump_type),
      .src1           (src1),
      .src2           (src2),
      .pc             (pc),
      .imm            (imm),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_taken      (out_taken),
      .out_next_pc    (out_next_pc),
      .out_link       (out_link),
      .out_mispredict (out_mispredict),
      .out_err        (out_err),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: resolution written straight from the architectural rules.
   typedef struct {
      bit          taken;
      bit          mis;
      bit          err;
      bit          counts;
      logic [31:0] next_pc;
      logic [31:0] link;
   } res_t;

   function automatic res_t resolve();
      res_t        r;
      logic [31:0] tgt;
      int          n;
      n        = $countones(jump_type);
      r.taken  = 0;
      r.mis    = 0;
      r.err    = 0;
      r.counts = 0;
      r.link   = pc + 32'd4;
      tgt      = pc + imm;
      if (n == 0) begin
         r.mis = pred_taken;
      end else if (n > 1) begin
         r.err = 1;
      end else begin
         r.counts = 1;
         if (jump_type[0]) r.taken = 1;
         if (jump_type[1]) begin
            r.taken = 1;
            tgt     = (src1 + imm) & 32'hFFFF_FFFE;
         end
         if (jump_type[2]) r.taken = (src1 == src2);
         if (jump_type[3]) r.taken = (src1 != src2);
         if (jump_type[4]) r.taken = ($signed(src1) <  $signed(src2));
         if (jump_type[5]) r.taken = ($signed(src1) >= $signed(src2));
         if (jump_type[6]) r.taken = (src1 <  src2);
         if (jump_type[7]) r.taken = (src1 >= src2);
         r.mis = (pred_taken != r.taken) || (r.taken && (pred_target != tgt));
      end
      r.next_pc = r.taken ? tgt : r.link;
      return r;
   endfunction

   bit   m_valid;
   res_t m;
   int   m_bcnt;
   int   m_mcnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0;
         m_bcnt  = 0;
         m_mcnt  = 0;
      end else begin
         if (m_valid && out_ready && !flush && m.counts) begin
            if (m_bcnt < CMAX) m_bcnt++;
            if (m.mis && m_mcnt < CMAX) m_mcnt++;
         end
         if (flush) begin
            m_valid = 0;
         end else if (!m_valid || out_ready) begin
            m_valid = in_valid;
            if (in_valid) m = resolve();
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
         chk("out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid) begin
            chk("out_taken", 64'(out_taken), 64'(m.taken));
            chk("out_next_pc", 64'(out_next_pc), 64'(m.next_pc));
            chk("out_link", 64'(out_link), 64'(m.link));
            chk("out_mispredict", 64'(out_mispredict), 64'(m.mis));
            chk("out_err", 64'(out_err), 64'(m.err));
         end else begin
            chk("idle_mispredict", 64'(out_mispredict), 64'd0);
            chk("idle_err", 64'(out_err), 64'd0);
         end
         chk("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
         chk("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mcnt));
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic [7:0] jt, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] p, input logic [31:0] im,
                      input logic pt, input logic [31:0] ptg);
      in_valid    = 1'b1;
      jump_type   = jt;
      src1        = s1;
      src2        = s2;
      pc          = p;
      imm         = im;
      pred_taken  = pt;
      pred_target = ptg;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      jump_type  = 8'h00;
      pred_taken = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      src1 = '0; src2 = '0; pc = '0; imm = '0; pred_target = '0;
      idle();
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_next_pc", 64'(out_next_pc), 64'd0);
      chk("rst_branch_cnt", 64'(branch_cnt), 64'd0);
      chk("rst_mispredict_cnt", 64'(mispredict_cnt), 64'd0);
      cyc();
      cyc();
      rst = 1'b0;
      chk("rel_in_ready", 64'(in_ready), 64'd1);

      // beq taken, predicted not-taken
      req(8'h04, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0);
      cyc();
      chk("beq_taken", 64'(out_taken), 64'd1);
      chk("beq_next_pc", 64'(out_next_pc), 64'h120);
      chk("beq_mispredict", 64'(out_mispredict), 64'd1);

      // signed vs unsigned compares on the same operands
      req(8'h10, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1, 32'h210);
      cyc();
      chk("beq_mis_cnt", 64'(mispredict_cnt), 64'd1);
      chk("blt_taken", 64'(out_taken), 64'd1);
      req(8'h40, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1, 32'h210);
      cyc();
      chk("bltu_taken", 64'(out_taken), 64'd0);
      req(8'h80, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1, 32'h210);
      cyc();
      chk("bgeu_taken", 64'(out_taken), 64'd1);

      // jalr clears bit 0 of the sum
      req(8'h02, 32'h1001, 32'h0, 32'h300, 32'h2, 1'b1, 32'h1002);
      cyc();
      chk("jalr_next_pc", 64'(out_next_pc), 64'h1002);
      chk("jalr_link", 64'(out_link), 64'h304);
      chk("jalr_mispredict", 64'(out_mispredict), 64'd0);
      idle();
      cyc();
      chk("seq_branch_cnt", 64'(branch_cnt), 64'd5);
      chk("seq_mis_cnt", 64'(mispredict_cnt), 64'd2);

      // back-pressure with three queued requests
      out_ready = 1'b0;
      req(8'h04, 32'd1, 32'd2, 32'h400, 32'h40, 1'b0, 32'h0);
      cyc();
      chk("bp_first_pc", 64'(out_next_pc), 64'h404);
      req(8'h08, 32'd1, 32'd2, 32'h410, 32'h40, 1'b1, 32'h450);
      cyc();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold1", 64'(out_next_pc), 64'h404);
      cyc();
      chk("bp_hold2", 64'(out_next_pc), 64'h404);
      out_ready = 1'b1;
      cyc();
      chk("bp_second_pc", 64'(out_next_pc), 64'h450);
      req(8'h01, 32'd0, 32'd0, 32'h500, 32'h8, 1'b1, 32'h508);
      cyc();
      chk("bp_third_pc", 64'(out_next_pc), 64'h508);
      idle();
      cyc();
      chk("bp_branch_cnt", 64'(branch_cnt), 64'd8);

      // flush kills held result and same-cycle request
      out_ready = 1'b0;
      req(8'h04, 32'd3, 32'd3, 32'h600, 32'h10, 1'b0, 32'h0);
      cyc();
      chk("fl_held", 64'(out_valid), 64'd1);
      req(8'h04, 32'd3, 32'd3, 32'h700, 32'h10, 1'b0, 32'h0);
      flush = 1'b1;
      out_ready = 1'b1;
      cyc();
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_branch_cnt", 64'(branch_cnt), 64'd8);
      chk("fl_mis_cnt", 64'(mispredict_cnt), 64'd2);
      flush = 1'b0;
      idle();
      cyc();
      chk("fl_dropped", 64'(out_valid), 64'd0);

      // illegal and non-branch encodings
      req(8'h05, 32'd1, 32'd1, 32'h800, 32'h10, 1'b1, 32'h810);
      cyc();
      chk("ill_err", 64'(out_err), 64'd1);
      chk("ill_taken", 64'(out_taken), 64'd0);
      chk("ill_mispredict", 64'(out_mispredict), 64'd0);
      req(8'h00, 32'd1, 32'd1, 32'h900, 32'h10, 1'b1, 32'h910);
      cyc();
      chk("nb_mispredict", 64'(out_mispredict), 64'd1);
      chk("nb_next_pc", 64'(out_next_pc), 64'h904);
      idle();
      cyc();
      chk("nb_branch_cnt", 64'(branch_cnt), 64'd8);
      chk("nb_mis_cnt", 64'(mispredict_cnt), 64'd2);

      // counter saturation
      for (int i = 0; i < 20; i++) begin
         req(8'h04, 32'd7, 32'd7, 32'h1000 + 32'(i * 16), 32'h40, 1'b0, 32'h0);
         cyc();
      end
      idle();
      cyc();
      chk("sat_branch_cnt", 64'(branch_cnt), 64'hF);
      chk("sat_mis_cnt", 64'(mispredict_cnt), 64'hF);

      // asynchronous reset while a result is held
      out_ready = 1'b0;
      req(8'h04, 32'd7, 32'd7, 32'h2000, 32'h40, 1'b0, 32'h0);
      cyc();
      chk("ar_held", 64'(out_valid), 64'd1);
      idle();
      rst = 1'b1;
      #1;
      chk("ar_valid", 64'(out_valid), 64'd0);
      chk("ar_mispredict", 64'(out_mispredict), 64'd0);
      chk("ar_branch_cnt", 64'(branch_cnt), 64'd0);
      chk("ar_mis_cnt", 64'(mispredict_cnt), 64'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      chk("ar_in_ready", 64'(in_ready), 64'd1);
      cyc();
      out_ready = 1'b1;
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of operands, PC, immediate and targets.
REQ-002 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-007 SHALL have port jump_type  input  8  one-hot opcode: bit0 jal, 1 jalr, 2 beq, 3 bne, 4 blt, 5 bge, 6 bltu, 7 bgeu.
REQ-008 SHALL have ports src1, src2, pc, imm  input  XLEN each  operands, instruction PC and sign-extended immediate.
REQ-009 SHALL have ports pred_taken  input  1 and pred_target  input  XLEN  front-end prediction.
REQ-010 SHALL have port flush  input  1  kills the held result and any same-cycle request.
REQ-011 SHALL have port out_valid  output  1 and out_ready  input  1  result handshake.
REQ-012 SHALL have ports out_taken  output  1, out_next_pc  output  XLEN, out_link  output  XLEN  resolved direction, correct next PC, pc+4.
REQ-013 SHALL have ports out_mispredict  output  1 and out_err  output  1  redirect request and illegal-opcode flag.
REQ-014 SHALL have ports branch_cnt, mispredict_cnt  output  CNT_W each  performance counters.

Function
REQ-015 SHALL resolve combinationally from inputs and register the result in a single output register; latency 1 cycle from acceptance to out_valid.
REQ-016 SHALL drive in_ready = ~out_valid | out_ready; accept and retire in the same cycle sustains 1 request/cycle.
REQ-017 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-018 SHALL compute signed compare (blt/bge) and unsigned compare (bltu/bgeu) over XLEN bits via one subtractor; bge = ~blt, bgeu = ~bltu.
REQ-019 SHALL set taken = 1 for jal/jalr; for conditional branches per compare result.
REQ-020 SHALL compute target = (src1+imm) with bit0 cleared for jalr, else pc+imm; all sums modulo 2^XLEN (wrap, no overflow flag).
REQ-021 SHALL set out_next_pc = taken ? target : pc+4, and out_link = pc+4.
REQ-022 SHALL set mispredict = (pred_taken != taken) | (taken & pred_target != target).
REQ-023 SHALL treat jump_type == 0 as non-branch: taken 0, mispredict = pred_taken, no counter update.
REQ-024 SHALL treat jump_type with more than one bit set as illegal: out_err 1, taken 0, mispredict 0, counters unchanged.
REQ-025 SHALL clear out_valid on the edge after flush=1, and SHALL not accept a request in a flush cycle (in_ready may be high but the request is dropped).
REQ-026 SHALL increment branch_cnt on each retire (out_valid & out_ready & ~flush) of a legal nonzero jump_type, and mispredict_cnt additionally when out_mispredict; both saturate at all-ones.
REQ-027 SHALL keep out_mispredict/out_err at 0 whenever out_valid is 0.

Reset
REQ-028 SHALL on rst clear out_valid, out_taken, out_mispredict, out_err, out_next_pc, out_link, branch_cnt and mispredict_cnt to 0, immediately and independent of clk.
REQ-029 SHALL discard any held result when rst asserts mid-operation; in_ready = 1 from reset release.

Structure
REQ-030 SHALL take jump_type bit indices and the XLEN default from the shared core package constants.
REQ-031 SHALL instantiate one sub-module branch_cmp (combinational eq/lt/ltu from one subtractor); the output register and counters stay in the top.

Verification
REQ-032 beq src1=src2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle out_taken 1, out_next_pc 0x120, out_mispredict 1, mispredict_cnt 1.
REQ-033 blt src1=0xFFFFFFFF, src2=1 -> taken 1; bltu same operands -> taken 0; bgeu -> taken 1.
REQ-034 jalr src1=0x1001, imm=0x2, pred_taken=1, pred_target=0x1002 -> out_next_pc 0x1002, out_link pc+4, out_mispredict 0.
REQ-035 back-to-back 3 requests with out_ready held 0 for 2 cycles -> in_ready 0 while full, first result stable, no loss or duplication, branch_cnt 3 at end.
REQ-036 flush asserted with result held and new request present -> out_valid 0 next cycle, request dropped, counters unchanged.
REQ-037 jump_type=0x05 -> out_err 1, taken 0; mispredict_cnt preset near all-ones via CNT_W=4 saturates at 0xF.
